// File: rtl/sram_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_mem_ctrl
// Description : MEM-stage access controller for an external multi-cycle SRAM.
//               Translates ALU byte addresses into SRAM word addresses and
//               runs each load/store through a wait-state FSM, holding
//               'ready' low so the pipeline freezes until the access is done.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_mem_ctrl #(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 18,
  parameter int          WAIT_STATES = 5,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_we_n
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Counter value on the final ACCESS cycle (WAIT_STATES is limited to 1..15).
  localparam logic [3:0] c_LAST_CNT = 4'(WAIT_STATES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic              r_is_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dq_out;
  logic [DATA_W-1:0] r_rdata;

  logic              w_req;
  logic              w_last;
  logic              w_ready;
  logic              w_we_n;
  logic              w_oe;
  logic [ADDR_W-1:0] w_word;

  // A store wins over a load when both are requested.
  assign w_req  = rd_en | wr_en;
  // 32-bit wrapping subtract, then byte->word; high bits alias silently.
  assign w_word = ADDR_W'((address - BASE_ADDR) >> 2);
  assign w_last = (r_cnt == c_LAST_CNT);

  // State register; an asynchronous reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and SRAM strobe / ready decode.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b1;
    w_we_n      = 1'b1;
    w_oe        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = ~w_req;
        if (w_req) begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_ready = 1'b0;
        w_we_n  = ~r_is_wr;
        w_oe    = r_is_wr;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request latch, wait counter and load-data capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= 4'd0;
      r_is_wr  <= 1'b0;
      r_addr   <= '0;
      r_dq_out <= '0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr   <= w_word;
            r_dq_out <= wdata;
            r_is_wr  <= wr_en;
            r_cnt    <= 4'd0;
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_last && !r_is_wr) begin
            r_rdata <= sram_dq_in;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rdata       = r_rdata;
  assign ready       = w_ready;
  assign sram_addr   = r_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = w_oe;
  assign sram_we_n   = w_we_n;

endmodule
`default_nettype wire

// File: tb/tb_sram_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_mem_ctrl
// Description : Self-checking bench for sram_mem_ctrl with a behavioural
//               SRAM, a reference memory model and an expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_mem_ctrl;

  localparam int WS = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [31:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  logic        wr_en1, rd_en1;
  logic [31:0] address1, wdata1;
  logic [31:0] rdata1;
  logic        ready1;
  logic [17:0] sram_addr1;
  logic [31:0] sram_dq_out1, sram_dq_in1;
  logic        sram_dq_oe1, sram_we_n1;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic        is_wr;
    logic [17:0] word;
    logic [31:0] wd;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] sram [256];
  logic [31:0] mdl  [256];
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  sram_mem_ctrl #(.DATA_W(32), .ADDR_W(18), .WAIT_STATES(WS), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .wdata(wdata), .rdata(rdata), .ready(ready), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n)
  );

  sram_mem_ctrl #(.DATA_W(32), .ADDR_W(18), .WAIT_STATES(1), .BASE_ADDR(32'd1024)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1), .address(address1),
    .wdata(wdata1), .rdata(rdata1), .ready(ready1), .sram_addr(sram_addr1),
    .sram_dq_out(sram_dq_out1), .sram_dq_in(sram_dq_in1), .sram_dq_oe(sram_dq_oe1),
    .sram_we_n(sram_we_n1)
  );

  // Behavioural SRAM: asynchronous read, write on clock edge while we_n low.
  assign sram_dq_in  = sram[sram_addr[7:0]];
  assign sram_dq_in1 = 32'hC0DE_0000 ^ {14'd0, sram_addr1};

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 32'h1000_0000 + i;
    forever begin
      @(posedge clk);
      if (!sram_we_n) sram[sram_addr[7:0]] = sram_dq_out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one access (caller is at a falling edge with the DUT in IDLE) and
  // follow it to its DONE cycle. chg_at>0 changes address/wdata on that
  // ready-low cycle to show mid-access inputs are ignored.
  task automatic run_op(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] wd, input int chg_at);
    exp_t        e;
    exp_t        p;
    logic [31:0] diff;
    int          low;
    bit          done;
    diff    = addr - 32'd1024;
    e.is_wr = wr;
    e.word  = diff[19:2];
    e.wd    = wd;
    if (wr) begin
      mdl[e.word[7:0]] = wd;
    end else begin
      exp_rdata = mdl[e.word[7:0]];
    end
    e.rd = exp_rdata;
    sb.push_back(e);
    wr_en = wr; rd_en = rd; address = addr; wdata = wd;
    low  = 0;
    done = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (!ready) begin
        low++;
        if (low > 1) begin
          chk("acc_addr", 32'(sram_addr), 32'(e.word));
          chk("acc_we_n", 32'(sram_we_n), 32'(!e.is_wr));
          chk("acc_oe",   32'(sram_dq_oe), 32'(e.is_wr));
          if (e.is_wr) chk("acc_dq_out", sram_dq_out, e.wd);
        end
        if (low == chg_at) begin
          address = 32'd2048;
          wdata   = 32'h22;
        end
      end else begin
        done = 1;
        if (sb.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          p = sb.pop_front();
          chk("low_cycles", 32'(low), 32'(WS + 1));
          chk("done_we_n", 32'(sram_we_n), 32'd1);
          chk("done_oe", 32'(sram_dq_oe), 32'd0);
          chk("done_rdata", rdata, p.rd);
        end
      end
      @(negedge clk);
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int          low1;
    int          wlow1;
    bit          fin;
    for (int i = 0; i < 256; i++) mdl[i] = 32'h1000_0000 + i;
    exp_rdata = 32'd0;
    rst = 1'b0;
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1064; wdata = 32'hA5A5_0001;
    wr_en1 = 1'b0; rd_en1 = 1'b0; address1 = 32'd0; wdata1 = 32'd0;

    // Reset held with a pending store: nothing may reach the SRAM.
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_we_n",  32'(sram_we_n), 32'd1);
      chk("rst_oe",    32'(sram_dq_oe), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    run_op(1'b1, 1'b0, 32'd1064, 32'hA5A5_0001, 0);

    // Write then read back.
    run_op(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, 0);
    run_op(1'b0, 1'b1, 32'd1028, 32'd0, 0);

    // Back-to-back reads with rd_en held high.
    run_op(1'b0, 1'b1, 32'd1024, 32'd0, 0);
    run_op(1'b0, 1'b1, 32'd1032, 32'd0, 0);
    run_op(1'b0, 1'b1, 32'd1040, 32'd0, 0);

    // Simultaneous rd/wr acts as a write; read it back afterwards.
    run_op(1'b1, 1'b1, 32'd1036, 32'h55, 0);
    run_op(1'b0, 1'b1, 32'd1036, 32'd0, 0);

    // Inputs changed during ACCESS cycle 2 must be ignored.
    run_op(1'b1, 1'b0, 32'd1024, 32'h11, 3);
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk); #1;
    chk("idle_ready", 32'(ready), 32'd1);
    chk("idle_we_n",  32'(sram_we_n), 32'd1);
    @(negedge clk);
    run_op(1'b0, 1'b1, 32'd1024, 32'd0, 0);
    chk("sram_word0", sram[0], 32'h11);
    chk("sram_word3", sram[3], 32'h55);
    chk("sram_word10", sram[10], 32'hA5A5_0001);
    rd_en = 1'b0;
    @(negedge clk);

    // Asynchronous reset in ACCESS cycle 3 of a read.
    rd_en = 1'b1; address = 32'd1040;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_state", 32'(dut.r_state), 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    chk("arst_we_n",  32'(sram_we_n), 32'd1);
    chk("arst_addr",  32'(sram_addr), 32'd0);
    chk("arst_ready", 32'(ready), 32'd0);
    rd_en = 1'b0;
    exp_rdata = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    repeat (WS + 3) begin
      @(negedge clk); #1;
      chk("post_rst_ready", 32'(ready), 32'd1);
      chk("post_rst_rdata", rdata, 32'd0);
    end

    // WAIT_STATES=1 instance: read then write, each ready-low for 2 cycles.
    @(negedge clk);
    rd_en1 = 1'b1; address1 = 32'd1052;
    low1 = 0; fin = 0;
    for (int c = 0; c < 20 && !fin; c++) begin
      #1;
      if (!ready1) low1++; else fin = 1;
      @(negedge clk);
    end
    chk("ws1_done", 32'(fin), 32'd1);
    chk("ws1_rd_low", 32'(low1), 32'd2);
    chk("ws1_rdata", rdata1, 32'hC0DE_0007);
    rd_en1 = 1'b0; wr_en1 = 1'b1; address1 = 32'd1024; wdata1 = 32'h77;
    low1 = 0; wlow1 = 0; fin = 0;
    for (int c = 0; c < 20 && !fin; c++) begin
      #1;
      if (!sram_we_n1) wlow1++;
      if (!ready1) low1++; else fin = 1;
      @(negedge clk);
    end
    wr_en1 = 1'b0;
    chk("ws1_wr_low", 32'(low1), 32'd2);
    chk("ws1_we_cycles", 32'(wlow1), 32'd1);
    chk("ws1_rdata_hold", rdata1, 32'hC0DE_0007);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Parametrised memory-access controller that replaces the single-cycle data memory in the MEM stage of the 5-stage pipeline with an external, multi-cycle SRAM.
- Translates the ALU byte address into an SRAM word address and runs each read or write through a wait-state FSM.
- Drives `ready` low while an access is in flight, so the pipeline registers (IF/ID/EXE/MEM) freeze until the access completes.

Parameters:
- DATA_W, 32, data word width (pipeline and SRAM).
- ADDR_W, 18, SRAM word-address width.
- WAIT_STATES, 5, SRAM access cycles per transaction; legal range 1 to 15.
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  MEM-stage store request.
- rd_en  in  1  MEM-stage load request.
- address  in  32  byte address from the ALU result.
- wdata  in  DATA_W  store data (reg2 value).
- rdata  out  DATA_W  load data, registered.
- ready  out  1  high means the pipeline may advance; low means freeze all stage registers.
- sram_addr  out  ADDR_W  SRAM word address.
- sram_dq_out  out  DATA_W  data driven to SRAM.
- sram_dq_in  in  DATA_W  data returned from SRAM.
- sram_dq_oe  out  1  tristate enable for sram_dq_out; high during write access.
- sram_we_n  out  1  SRAM write strobe, active low.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, wait counter=0, rdata=0.
  - sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
  - A reset mid-access aborts the transaction immediately; no SRAM write completes after rst falls.
- Request: req = rd_en | wr_en. If both are high, the access is a write; rd_en is ignored.
- Address translation: word = (address - BASE_ADDR) >> 2, truncated to ADDR_W bits.
  - The subtraction is 32-bit and wraps.
  - Out-of-range addresses are not flagged; they alias modulo 2^ADDR_W.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If req: latch translated address into sram_addr, wdata into sram_dq_out, and the operation type (write/read); counter=0; go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - sram_addr and sram_dq_out are held at the latched values.
  - Write: sram_we_n=0 and sram_dq_oe=1 in every ACCESS cycle.
  - Read: sram_we_n=1 and sram_dq_oe=0.
  - Counter increments each cycle. On the edge where counter==WAIT_STATES-1: for a read, rdata<=sram_dq_in; then go to DONE.
- DONE: sram_we_n=1, sram_dq_oe=0; unconditionally go to IDLE next cycle.
- ready (combinational):
  - IDLE: ready = ~req.
  - ACCESS: ready = 0.
  - DONE: ready = 1.
- Latency: a request first seen in IDLE holds ready low for exactly WAIT_STATES+1 cycles. ready is high for one cycle in DONE, and the pipeline advances on that edge.
- rdata is valid from DONE onward and holds until the next read completes. Writes do not change rdata.
- Requests are latched at IDLE; changes to wr_en, rd_en, address or wdata during ACCESS or DONE are ignored.
- A request held high through DONE is treated as the next instruction's request in the following IDLE. Back-to-back accesses therefore take WAIT_STATES+2 cycles each.
- No request: ready stays 1 and all SRAM outputs stay idle (we_n=1, oe=0).

Test Plan:
- Reset: hold rst=0 for 3 cycles with wr_en=1, then release. Required: during reset we_n=1, oe=0, rdata=0, ready=0; after release a write starts on the first edge.
- Write then read (WAIT_STATES=5): write address=1028, wdata=0xDEADBEEF. Required: sram_addr=1, we_n=0 for 5 cycles, ready low 6 cycles. Then read address=1028. Required: rdata=0xDEADBEEF in DONE, ready high for exactly 1 cycle.
- Back-to-back: 3 consecutive reads to addresses 1024, 1032, 1040, holding rd_en high. Required: sram_addr sequence 0, 2, 4; each access takes 7 cycles; 3 single-cycle ready pulses.
- Simultaneous rd_en=1, wr_en=1: address=1036, wdata=0x55. Required: write to word 3; rdata unchanged.
- Mid-access change: start a write to 1024 with 0x11, then at ACCESS cycle 2 switch address to 2048 and wdata to 0x22. Required: sram_addr stays 0, dq_out stays 0x11.
- Async reset mid-read at ACCESS cycle 3. Required: on the same cycle state=IDLE, rdata=0, we_n=1; no DONE pulse. Also rerun with WAIT_STATES=1 and confirm ready is low for 2 cycles.
